// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port plus packed-word valid/ready bundle.
interface fifo_rd_packer_if #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
);
    logic [WIDTH-1:0]      rdata;
    logic                  empty;
    logic                  ren;
    logic [WIDTH*PACK-1:0] out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_valid;
    logic                  out_ready;
    modport master (input rdata, empty, out_ready, output ren, out_data, out_keep, out_valid);
    modport slave (output rdata, empty, out_ready, input ren, out_data, out_keep, out_valid);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs PACK first-word-fall-through FIFO entries into one valid/ready word.
// Define FIFO_RD_TIMEOUT_EN to flush stalled partial words after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int WIDTH   = 8,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 16
) (
    input logic               rclk,
    input logic               rrst,
    fifo_rd_packer_if.master  bus
);
    localparam int CW = $clog2(PACK);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);
    typedef enum logic {ACCUM, HOLD} state_e;
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH*PACK-1:0] data_q, data_d;
    logic [PACK-1:0]       keep_q, keep_d;
    logic                  pop, flush;

    if (PACK < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_rd_packer: PACK must be >= 2 and TIMEOUT >= 1");
    end

    // ren already implies !empty, so it doubles as the pop strobe
    assign bus.ren       = !rrst && !bus.empty && (state_q == ACCUM || bus.out_ready);
    assign pop           = bus.ren;
    assign bus.out_valid = state_q == HOLD;
    assign bus.out_data  = data_q;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
    assign flush = state_q == ACCUM && cnt_q != '0 && !pop && idle_q == IW'(TIMEOUT - 1);
    assign idle_d = pop ? '0 : (state_q == ACCUM && cnt_q != '0) ? idle_q + IW'(1) : idle_q;
    assign bus.out_keep = keep_q;
    always_ff @(posedge rclk) begin
        if (rrst) idle_q <= '0;
        else      idle_q <= idle_d;
    end
`else
    assign flush = 1'b0;
    // only full words are ever presented, so the mask is all-ones exactly while holding
    assign bus.out_keep = keep_q & {PACK{state_q == HOLD}};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (state_q == HOLD && bus.out_ready) begin
            state_d = ACCUM;
            cnt_d   = '0;
            data_d  = '0;
            keep_d  = '0;
        end
        if (pop) begin
            data_d[cnt_d*WIDTH +: WIDTH] = bus.rdata;
            keep_d[cnt_d]                = 1'b1;
            state_d                      = cnt_d == LAST ? HOLD : ACCUM;
            cnt_d                        = cnt_d == LAST ? '0 : cnt_d + CW'(1);
        end
        if (flush) begin
            state_d = HOLD;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed tests for fifo_rd_packer against a queue-modelled FIFO.
module tb_fifo_rd_packer;
    logic rclk = 1'b0;
    logic rrst;
    int   n_checks = 0;
    int   n_pass = 0;
    int   pops = 0;
    logic [7:0] fifo[$];

    fifo_rd_packer_if #(.WIDTH(8), .PACK(4)) bus ();
    fifo_rd_packer #(.WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (.rclk(rclk), .rrst(rrst), .bus(bus));

    always #5 rclk = ~rclk;

    task automatic upd();
        bus.empty = fifo.size() == 0;
        bus.rdata = fifo.size() != 0 ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        upd();
    endtask

    task automatic tick();
        logic p;
        @(negedge rclk);
        p = bus.ren && !bus.empty;
        @(posedge rclk);
        #1;
        if (p) begin
            void'(fifo.pop_front());
            pops++;
        end
        upd();
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        fifo.delete();
        upd();
        tick();
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        push(8'h99);
        #1;
        n_checks++; if (bus.ren !== 1'b0) $display("FAIL reset_ren_early got %0b want 0", bus.ren); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.ren !== 1'b0) $display("FAIL reset_ren got %0b want 0", bus.ren); else n_pass++;
        n_checks++; if (pops !== 0) $display("FAIL reset_pops got %0d want 0", pops); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_keep !== 4'h0) $display("FAIL reset_keep got %b want 0000", bus.out_keep); else n_pass++;
        fifo.delete();
        upd();
        rrst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] kp;
`ifdef FIFO_RD_TIMEOUT_EN
        kp = 4'b0111;
`else
        kp = 4'b0000;
`endif
        pops = 0;
        bus.out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (3) tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_partial_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_keep !== kp) $display("FAIL basic_partial_keep got %b want %b", bus.out_keep, kp); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h00332211) $display("FAIL basic_partial_data got %h want 00332211", bus.out_data); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %0b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h44332211) $display("FAIL basic_data got %h want 44332211", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_keep !== 4'hF) $display("FAIL basic_keep got %b want 1111", bus.out_keep); else n_pass++;
        n_checks++; if (pops !== 4) $display("FAIL basic_pops got %0d want 4", pops); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h0) $display("FAIL basic_drain_data got %h want 0", bus.out_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [3:0] k1;
`ifdef FIFO_RD_TIMEOUT_EN
        k1 = 4'b0001;
`else
        k1 = 4'b0000;
`endif
        pops = 0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'h50 + 8'(i));
        repeat (6) tick();
        n_checks++; if (pops !== 4) $display("FAIL bp_pops got %0d want 4", pops); else n_pass++;
        n_checks++; if (bus.ren !== 1'b0) $display("FAIL bp_ren got %0b want 0", bus.ren); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid got %0b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h54535251) $display("FAIL bp_data got %h want 54535251", bus.out_data); else n_pass++;
        tick();
        n_checks++; if (bus.out_data !== 32'h54535251) $display("FAIL bp_stable got %h want 54535251", bus.out_data); else n_pass++;
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.ren !== 1'b1) $display("FAIL bp_ren_ready got %0b want 1", bus.ren); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_xfer_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (pops !== 5) $display("FAIL bp_xfer_pops got %0d want 5", pops); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h00000055) $display("FAIL bp_xfer_data got %h want 00000055", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_keep !== k1) $display("FAIL bp_xfer_keep got %b want %b", bus.out_keep, k1); else n_pass++;
        repeat (3) tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_word2_valid got %0b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h58575655) $display("FAIL bp_word2_data got %h want 58575655", bus.out_data); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain_valid got %0b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        pops = 0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (4) tick();
        n_checks++; if (bus.out_data !== 32'h04030201 || bus.out_valid !== 1'b1) $display("FAIL b2b_word1 got %h/%0b want 04030201/1", bus.out_data, bus.out_valid); else n_pass++;
        tick();
        n_checks++; if (bus.out_data !== 32'h00000005 || bus.out_valid !== 1'b0) $display("FAIL b2b_lane0 got %h/%0b want 00000005/0", bus.out_data, bus.out_valid); else n_pass++;
        repeat (3) tick();
        n_checks++; if (bus.out_data !== 32'h08070605 || bus.out_valid !== 1'b1) $display("FAIL b2b_word2 got %h/%0b want 08070605/1", bus.out_data, bus.out_valid); else n_pass++;
        n_checks++; if (pops !== 8) $display("FAIL b2b_pops got %0d want 8", pops); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        pops = 0;
        bus.out_ready = 1'b0;
        push(8'hAA); push(8'hBB);
        repeat (2) tick();
`ifdef FIFO_RD_TIMEOUT_EN
        repeat (15) tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL to_early_valid got %0b want 0", bus.out_valid); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL to_valid got %0b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h0000BBAA) $display("FAIL to_data got %h want 0000bbaa", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_keep !== 4'b0011) $display("FAIL to_keep got %b want 0011", bus.out_keep); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL to_drain_valid got %0b want 0", bus.out_valid); else n_pass++;
`else
        begin
            int seen;
            seen = 0;
            repeat (100) begin
                tick();
                if (bus.out_valid !== 1'b0) seen++;
            end
            n_checks++; if (seen !== 0) $display("FAIL to_off_valid got %0d valid cycles want 0", seen); else n_pass++;
            n_checks++; if (bus.out_keep !== 4'h0) $display("FAIL to_off_keep got %b want 0000", bus.out_keep); else n_pass++;
        end
`endif
        n_checks++; if (pops !== 2) $display("FAIL to_pops got %0d want 2", pops); else n_pass++;
        do_reset();
    endtask

    task automatic test_mid_reset();
        logic [3:0] k1;
        pops = 0;
        bus.out_ready = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
        k1 = 4'b0001;
        push(8'hAA); push(8'hBB);
        repeat (2) tick();
        repeat (15) tick();
        push(8'hCC);
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL coll_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_keep !== 4'b0111) $display("FAIL coll_keep got %b want 0111", bus.out_keep); else n_pass++;
        n_checks++; if (pops !== 3) $display("FAIL coll_pops got %0d want 3", pops); else n_pass++;
        push(8'hDD);
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL coll_word_valid got %0b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'hDDCCBBAA || bus.out_keep !== 4'hF) $display("FAIL coll_word got %h/%b want ddccbbaa/1111", bus.out_data, bus.out_keep); else n_pass++;
`else
        k1 = 4'b0000;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        repeat (4) tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL mid_hold_valid got %0b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'hC4C3C2C1) $display("FAIL mid_hold_data got %h want c4c3c2c1", bus.out_data); else n_pass++;
`endif
        push(8'hEE);
        rrst = 1'b1;
        #1;
        n_checks++; if (bus.ren !== 1'b0) $display("FAIL mid_rst_ren got %0b want 0", bus.ren); else n_pass++;
        tick();
        rrst = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h0 || bus.out_keep !== 4'h0) $display("FAIL mid_rst_clear got %h/%b want 0/0000", bus.out_data, bus.out_keep); else n_pass++;
        n_checks++; if (pops !== 4) $display("FAIL mid_rst_pops got %0d want 4", pops); else n_pass++;
        tick();
        n_checks++; if (pops !== 5) $display("FAIL mid_lane0_pops got %0d want 5", pops); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h000000EE) $display("FAIL mid_lane0_data got %h want 000000ee", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_keep !== k1) $display("FAIL mid_lane0_keep got %b want %b", bus.out_keep, k1); else n_pass++;
    endtask

    initial begin
        rrst = 1'b1;
        bus.out_ready = 1'b0;
        upd();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
